hazard_ctrl: RTL

Central pipeline sequencing unit for the five-stage core. It decides every cycle whether the fetch/decode register and the PC advance, hold or flush, and whether a bubble goes into ID/EX. It arbitrates between three hazard sources: data-memory wait, load-use and branch/jump redirect. It also keeps saturating stall and flush counters and a memory-wait watchdog. It drives the `hd_i`/`flush_i` inputs of the IF/ID register and the PC write enable.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing unit: arbitrates memory wait, load-use and redirect hazards,
// keeps saturating stall/flush counters and a memory-wait watchdog.
module hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_hd_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, rd, mm, freeze;

  assign lu = ex_memread_i && (ex_rt_i != 5'd0) &&
              ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign rd = branch_taken_i | jump_i;
  assign mm = mem_req_i & ~mem_ack_i;
  // ERR ignores the memory interface entirely
  assign freeze = ((state_q == StMemWait) && !mem_ack_i) || ((state_q == StRun) && mm);

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_hd_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_stall_o = 1'b0;
    if (rst_i) begin
      // Fill the pipe with NOPs while reset is held
      pc_write_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_write_o    = 1'b0;
      ifid_hd_o     = 1'b1;
      exmem_stall_o = 1'b1;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_hd_o     = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (rd) begin
      ifid_flush_o  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      StRun: begin
        if (mm) begin
          state_d = StMemWait;
          wait_d  = '0;
        end
      end
      StMemWait: begin
        if (mem_ack_i) begin
          state_d = StRun;
        end else if (wait_q == WaitLast) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
